multiword_add_sequencer: RTL and testbench

- Performs wide add/subtract (32*WORDS bits) by sequencing one shared 32-bit adder datapath (A, B, Cin -> SUM, Cout, Overflow) over WORDS cycles, least-significant word first.
- The carry is registered between words.
- Sits between a requesting unit (start/done handshake) and the adder; the adder is instantiated internally and is the only arithmetic resource used.

---
 rtl/multiword_add_sequencer.sv | 151 +++++++++++++++
 tb/tb_multiword_add_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_sequencer.sv
// Wide (32*WORDS-bit) add/subtract built by stepping one shared 32-bit adder
// over the operand words, least-significant first, with the carry registered between words.

module mwas_adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout,
    output logic        overflow
);
    logic [32:0] full_s;

    assign full_s   = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    assign sum      = full_s[31:0];
    assign cout     = full_s[32];
    assign overflow = (a[31] == b[31]) && (full_s[31] != a[31]);
endmodule

module multiword_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sub,
    input  logic                cin,
    input  logic [32*WORDS-1:0] op_a,
    input  logic [32*WORDS-1:0] op_b,
    output logic                busy,
    output logic                done,
    output logic [32*WORDS-1:0] result,
    output logic                cout,
    output logic                overflow
);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [IDX_W-1:0]        idx_r;
    logic                    carry_r;
    logic [WORDS-1:0][31:0]  a_r;
    logic [WORDS-1:0][31:0]  b_r;
    logic [WORDS-1:0][31:0]  sum_r;
    logic [WORDS-1:0][31:0]  sum_merge_s;
    logic [31:0]             add_sum_s;
    logic                    add_cout_s;
    logic                    add_ovf_s;
    logic                    accept_s;
    logic                    last_s;
    logic                    busy_r;
    logic                    done_r;
    logic [32*WORDS-1:0]     result_r;
    logic                    cout_r;
    logic                    ovf_r;

    assign accept_s = (state_r == IDLE) && start;
    assign last_s   = (state_r == RUN) && (idx_r == LAST_IDX);

    mwas_adder32 u_adder (
        .a        (a_r[idx_r]),
        .b        (b_r[idx_r]),
        .cin      (carry_r),
        .sum      (add_sum_s),
        .cout     (add_cout_s),
        .overflow (add_ovf_s)
    );

    // Next-state decode: RUN lasts exactly WORDS cycles
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = RUN;
                else       state_next_s = IDLE;
            end
            RUN: begin
                if (idx_r == LAST_IDX) state_next_s = IDLE;
                else                   state_next_s = RUN;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Working sum with the current word folded in, so completion publishes every word at once
    always_comb begin
        sum_merge_s        = sum_r;
        sum_merge_s[idx_r] = add_sum_s;
    end

    // State register; busy is registered from the next-state decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == RUN);
        end
    end

    // Operand capture, per-word accumulation and completion outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r    <= '0;
            carry_r  <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            sum_r    <= '0;
            done_r   <= 1'b0;
            result_r <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else if (accept_s) begin
            // Subtraction is A + ~B + 1: invert B once here, force the initial carry
            a_r     <= op_a;
            b_r     <= sub ? ~op_b : op_b;
            carry_r <= sub ? 1'b1 : cin;
            idx_r   <= '0;
            sum_r   <= '0;
            done_r  <= 1'b0;
        end else if (state_r == RUN) begin
            sum_r[idx_r] <= add_sum_s;
            carry_r      <= add_cout_s;
            if (last_s) begin
                idx_r    <= '0;
                result_r <= sum_merge_s;
                cout_r   <= add_cout_s;
                ovf_r    <= add_ovf_s;
                done_r   <= 1'b1;
            end else begin
                idx_r  <= idx_r + IDX_W'(1);
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign result   = result_r;
    assign cout     = cout_r;
    assign overflow = ovf_r;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer (WORDS=4): reference results come
// from a full-width arithmetic model queued at issue time and popped on done.

module tb_multiword_add_sequencer;
    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    int   tests;
    int   fails;
    exp_t exp_q[$];
    exp_t last_exp;

    multiword_add_sequencer #(.WORDS(WORDS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .cin      (cin),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input logic c);
        logic [W-1:0] bb;
        logic [W:0]   full;
        exp_t         m;
        bb    = s ? ~b : b;
        full  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (s ? 1'b1 : c)};
        m.res = full[W-1:0];
        m.co  = full[W];
        m.ov  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return m;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic compare_out(input string tag);
        check({tag, "_done"}, W'(done), W'(1'b1));
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, W'(0), W'(1));
        end else begin
            last_exp = exp_q.pop_front();
            check({tag, "_result"}, result, last_exp.res);
            check({tag, "_cout"}, W'(cout), W'(last_exp.co));
            check({tag, "_ovf"}, W'(overflow), W'(last_exp.ov));
        end
    endtask

    // Issue one request at the current negedge, verify busy per cycle, latency and results
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic c, input string tag);
        int n;
        exp_q.push_back(model(a, b, s, c));
        op_a = a; op_b = b; sub = s; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            check({tag, "_busy"}, W'(busy), W'(1'b1));
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, W'(n), W'(WORDS));
        check({tag, "_busy_done"}, W'(busy), W'(1'b0));
        compare_out(tag);
    endtask

    logic [W-1:0] ones;
    logic [W-1:0] junk;
    logic [W-1:0] a2;
    logic [W-1:0] b2;

    initial begin
        tests = 0;
        fails = 0;
        ones  = '1;
        junk  = {4{32'hDEAD_BEEF}};
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", W'(busy), W'(1'b0));
        check("rst_done", W'(done), W'(1'b0));
        check("rst_result", result, W'(0));
        check("rst_cout", W'(cout), W'(1'b0));
        check("rst_ovf", W'(overflow), W'(1'b0));
        rst_n = 1'b1;
        @(negedge clk);

        // Carry ripple across the two lower words
        run_op({64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, W'(1), 1'b0, 1'b0, "ripple");
        check("ripple_const", result, {64'd1, 64'd0});
        @(negedge clk);
        check("ripple_done_drop", W'(done), W'(1'b0));

        run_op(ones, W'(0), 1'b0, 1'b1, "wrap");
        check("wrap_cout_const", W'(cout), W'(1'b1));
        run_op({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, 1'b0, "sovf");
        check("sovf_const", result, {1'b1, {(W-1){1'b0}}});
        run_op(W'(5), W'(7), 1'b1, 1'b1, "subA");
        check("subA_const", result, ones - W'(1));
        run_op(W'(7), W'(5), 1'b1, 1'b0, "subB");
        check("subB_const", result, W'(2));
        run_op({4{32'h89AB_CDEF}}, {4{32'h7654_3211}}, 1'b0, 1'b1, "mixed");

        // Handshake: start held high with junk operands during RUN, new request in the done cycle
        exp_q.push_back(model({4{32'h1234_5678}}, {4{32'h0F0F_0F0F}}, 1'b0, 1'b0));
        op_a = {4{32'h1234_5678}}; op_b = {4{32'h0F0F_0F0F}}; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        op_a = junk; op_b = junk; sub = 1'b1;
        for (int i = 0; i < WORDS; i++) begin
            check("hs_busy", W'(busy), W'(1'b1));
            check("hs_nodone", W'(done), W'(1'b0));
            @(negedge clk);
        end
        compare_out("hs_op1");
        a2 = {32'h0, 32'hFFFF_FFFF, 32'h1, 32'h8000_0000};
        b2 = {32'h0, 32'h1, 32'h2, 32'h8000_0000};
        exp_q.push_back(model(a2, b2, 1'b0, 1'b0));
        op_a = a2; op_b = b2; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        begin
            int n;
            n = 0;
            while (!done && n < 20) begin
                check("hs_busy2", W'(busy), W'(1'b1));
                check("hs_stable", result, last_exp.res);
                @(negedge clk);
                n++;
            end
            check("hs_latency2", W'(n), W'(WORDS));
        end
        compare_out("hs_op2");

        // Asynchronous reset while word index 2 is being processed
        op_a = ones; op_b = ones; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", W'(busy), W'(1'b0));
        check("arst_done", W'(done), W'(1'b0));
        check("arst_result", result, W'(0));
        check("arst_cout", W'(cout), W'(1'b0));
        check("arst_ovf", W'(overflow), W'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("arst_nodone", W'(done), W'(1'b0));
            @(negedge clk);
        end
        run_op(W'(1), W'(1), 1'b0, 1'b0, "post_rst");
        check("post_rst_const", result, W'(2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
